// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module  : if_stage_pkg
// Brief   : Shared fetch-pipeline constants, state encoding and PC helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
    localparam logic [31:0] c_nop_inst         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] c_pc_step          = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + c_pc_step;
    endfunction

endpackage : if_stage_pkg

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// Module  : if_stage_if
// Brief   : Instruction-memory request/ack bus between fetch and memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface : if_stage_if

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Brief   : Instruction fetch stage with stall hold buffer and redirect drop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc_default
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall_i,
    input  wire logic        redirect_i,
    input  wire logic [31:0] redirect_pc_i,
    if_stage_if.master       imem,
    output logic             ifid_valid_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_inst_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  buf_q, buf_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_inst_q, ifid_inst_d;

    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_pc_plus4;

    assign w_redirect_pc = align_pc(redirect_pc_i);
    assign w_pc_plus4    = next_pc(pc_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            buf_q        <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_inst_q  <= c_nop_inst;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            buf_q        <= buf_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        buf_d        = buf_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;

        unique case (state_q)
            ST_FETCH: begin
                if (redirect_i) begin
                    pc_d         = w_redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = c_nop_inst;
                    if (imem.imem_ack) begin
                        state_d = ST_FETCH;
                    end else begin
                        // Memory still owes us the old word; keep its address on the bus.
                        req_addr_d = pc_q;
                        state_d    = ST_DROP;
                    end
                end else if (imem.imem_ack) begin
                    if (stall_i) begin
                        buf_d   = imem.imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_inst_d  = imem.imem_rdata;
                        pc_d         = w_pc_plus4;
                    end
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = c_nop_inst;
                end
            end

            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d         = w_redirect_pc;
                    buf_d        = 32'h0000_0000;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = c_nop_inst;
                    state_d      = ST_FETCH;
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_inst_d  = buf_q;
                    pc_d         = w_pc_plus4;
                    state_d      = ST_FETCH;
                end
            end

            ST_DROP: begin
                if (redirect_i) begin
                    pc_d         = w_redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = c_nop_inst;
                end
                // An ack here retires the abandoned request, so fetching can resume.
                if (imem.imem_ack) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        if (!rst && (state_q != ST_HOLD)) begin
            imem.imem_req = 1'b1;
        end
        if (state_q == ST_DROP) begin
            imem.imem_addr = req_addr_q;
        end
    end

    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_inst_o  = ifid_inst_q;

endmodule : if_stage

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Brief   : Directed scoreboard bench for the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;

    if_stage_if imem_bus();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem          (imem_bus),
        .ifid_valid_o  (ifid_valid),
        .ifid_pc_o     (ifid_pc),
        .ifid_inst_o   (ifid_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode consumes the IF/ID word in any unstalled cycle where it is valid.
    always @(negedge clk) begin
        if (rst === 1'b0 && ifid_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ifid: got pc %h with empty queue (t=%0t)", ifid_pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check32("ifid_pc", ifid_pc, e.pc);
                check32("ifid_inst", ifid_inst, e.inst);
            end
        end
    end

    // One clock of stimulus, starting #1 after a rising edge.
    task automatic step(input logic exp_req, input logic [31:0] exp_addr, input logic ack,
                        input logic stl, input logic rd, input logic [31:0] rpc, input logic push);
        stall                = stl;
        redirect             = rd;
        redirect_pc          = rpc;
        imem_bus.imem_ack    = ack;
        imem_bus.imem_rdata  = ack ? tag(imem_bus.imem_addr) : 32'hDEAD_BEEF;
        if (push) exp_q.push_back('{pc: exp_addr, inst: tag(exp_addr)});
        @(negedge clk);
        check32("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
        if (exp_req) check32("imem_addr", imem_bus.imem_addr, exp_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        stall               = 1'b0;
        redirect            = 1'b0;
        redirect_pc         = 32'h0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check32("rst_imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check32("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        check32("rst_ifid_pc", ifid_pc, 32'h0);
        check32("rst_ifid_inst", ifid_inst, 32'h0000_0013);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        // Sequential fetch with ack every cycle
        step(1, 32'h0,   1, 0, 0, 32'h0, 1);
        step(1, 32'h4,   1, 0, 0, 32'h0, 1);
        // Stall on the ack at pc=8 for three cycles
        step(1, 32'h8,   1, 1, 0, 32'h0, 1);
        check32("hold_ifid_pc", ifid_pc, 32'h4);
        step(0, 32'h0,   0, 1, 0, 32'h0, 0);
        step(0, 32'h0,   0, 1, 0, 32'h0, 0);
        check32("hold_ifid_pc2", ifid_pc, 32'h4);
        step(0, 32'h0,   0, 0, 0, 32'h0, 0);
        step(1, 32'hC,   1, 0, 0, 32'h0, 1);
        // Redirect with ack at pc=16
        step(1, 32'h10,  1, 0, 1, 32'h100, 0);
        check32("redir_bubble", {31'd0, ifid_valid}, 32'd0);
        step(1, 32'h100, 1, 0, 0, 32'h0, 1);
        step(1, 32'h104, 0, 0, 0, 32'h0, 0);
        // Misaligned redirect target, then redirect while request outstanding
        step(1, 32'h104, 1, 0, 1, 32'h13, 0);
        step(1, 32'h10,  0, 0, 1, 32'h200, 0);
        step(1, 32'h10,  0, 0, 0, 32'h0, 0);
        step(1, 32'h10,  1, 0, 0, 32'h0, 0);
        step(1, 32'h200, 1, 0, 0, 32'h0, 1);
        step(1, 32'h204, 0, 0, 0, 32'h0, 0);
        // PC wrap at the top of the address space
        step(1, 32'h204, 1, 0, 1, 32'hFFFF_FFFC, 0);
        step(1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0, 1);
        step(1, 32'h0,   0, 0, 0, 32'h0, 0);
        // Redirect and stall together: redirect wins
        step(1, 32'h0,   1, 1, 1, 32'h300, 0);
        check32("redir_stall_bubble", {31'd0, ifid_valid}, 32'd0);
        step(1, 32'h300, 1, 0, 0, 32'h0, 1);
        step(1, 32'h304, 0, 0, 0, 32'h0, 0);
        // Redirect while holding a buffered word
        step(1, 32'h304, 1, 1, 0, 32'h0, 0);
        step(0, 32'h0,   0, 1, 1, 32'h400, 0);
        check32("hold_redir_bubble", {31'd0, ifid_valid}, 32'd0);
        step(1, 32'h400, 1, 0, 0, 32'h0, 1);
        step(1, 32'h404, 0, 0, 0, 32'h0, 0);
        // Reset while a dropped request is outstanding
        step(1, 32'h404, 0, 0, 1, 32'h500, 0);
        do_reset();
        step(1, 32'h0,   1, 0, 0, 32'h0, 1);
        step(1, 32'h4,   0, 0, 0, 32'h0, 0);
        step(1, 32'h4,   0, 0, 0, 32'h0, 0);
        check32("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_if_stage

`default_nettype wire
